bk_mp_add_ctrl: RTL and testbench
=================================

BK_MP_ADD_CTRL -- requirements
Module: bk_mp_add_ctrl

Interface
REQ-001 SHALL have parameter NWORDS, default 4, number of 32-bit words per operand (legal range 2..8).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, request valid.
REQ-005 SHALL have port in_ready, output, 1, controller can accept a request.
REQ-006 SHALL have port op_sub, input, 1, 0 = A+B, 1 = A-B.
REQ-007 SHALL have port a, input, 32*NWORDS, operand A, word 0 = bits [31:0].
REQ-008 SHALL have port b, input, 32*NWORDS, operand B.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port result, output, 32*NWORDS, sum/difference.
REQ-012 SHALL have port cout, output, 1, final carry; for subtract, 1 = no borrow.
REQ-013 SHALL have port ovf, output, 1, two's-complement overflow of the full-width operation.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL instantiate exactly one 32-bit brent_kung_adder and time-share it across all words; no other adder logic.
REQ-016 SHALL implement states IDLE, RUN, DONE.
REQ-017 In IDLE: in_ready=1, out_valid=0; on in_valid=1 latch a, b, op_sub, set word index k=0, set carry register to op_sub, go to RUN.
REQ-018 For subtract, the adder B input SHALL be the bitwise inverse of B word k; carry-in of word 0 is 1 (two's complement).
REQ-019 In RUN, each cycle: adder inputs = latched A word k, (inverted) B word k, and carry register; write sum into result word k; load carry register from adder cout; k increments.
REQ-020 When k=NWORDS-1 completes, SHALL go to DONE; RUN lasts exactly NWORDS cycles.
REQ-021 Latency: acceptance edge = cycle 0; out_valid SHALL rise at cycle NWORDS+1 (cycle 5 for NWORDS=4).
REQ-022 In DONE: out_valid=1; result, cout and ovf held stable until out_valid and out_ready are both high.
REQ-023 On the DONE handshake SHALL return to IDLE; in_ready rises the following cycle; there is no same-cycle accept.
REQ-024 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored, and latched operands SHALL not change.
REQ-025 ovf SHALL equal (A_msb == B'_msb) AND (result_msb != A_msb), where B' = post-inversion B and msb = bit 32*NWORDS-1.
REQ-026 cout SHALL be the carry register value after the last word.
REQ-027 The clock period SHALL exceed the adder worst-case propagation delay; the bench SHALL use a clock period of at least 20 ns.

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE, k=0, carry=0, result=0, cout=0, ovf=0, out_valid=0, busy=0; in_ready=1 from the next cycle.
REQ-029 rst asserted in RUN or DONE SHALL abort the operation; no out_valid is produced for the aborted request.
REQ-030 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification (NWORDS=4)
REQ-031 add: A = all ones (128 bits), B = 1 -> result=0, cout=1, ovf=0, out_valid at cycle 5.
REQ-032 sub: A=0, B=1 -> result = all ones, cout=0, ovf=0.
REQ-033 add: A = 0x7FFF...F, B = 1 -> result = 0x8000...0, cout=0, ovf=1; sub: A = 0x8000...0, B = 1 -> result = 0x7FFF...F, ovf=1.
REQ-034 Backpressure: hold out_ready=0 for 3 cycles in DONE while pulsing in_valid with new operands -> result stable, in_ready=0, no new acceptance; out_ready=1 -> IDLE the next cycle.
REQ-035 Reset mid-RUN: assert rst at cycle 2 -> out_valid never rises, busy=0, in_ready=1 next cycle; a following add of 5+7 -> result=12.
REQ-036 Back-to-back: two requests with in_valid held high -> second accepted exactly one cycle after the first output handshake; both results correct against a 128-bit reference model.

Source files
------------

// File: rtl/bk_mp_add_ctrl.sv
// Multi-word add/subtract controller that time-shares one
// 32-bit Brent-Kung adder across NWORDS words, LSW first.

module brent_kung_adder (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);

  always_comb begin
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] h;
    h = x ^ y;
    g = x & y;
    p = h;
    g[0] = g[0] | (p[0] & cin);
    for (int d = 1; d < 32; d = d * 2) begin
      for (int i = 2 * d - 1; i < 32; i = i + 2 * d) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    // down-sweep fills in the prefixes skipped by the up-sweep
    for (int d = 8; d > 0; d = d / 2) begin
      for (int i = 3 * d - 1; i < 32; i = i + 2 * d) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    s    = h ^ {g[30:0], cin};
    cout = g[31];
  end

endmodule

module bk_mp_add_ctrl #(
  parameter int NWORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op_sub,
  input  logic [32*NWORDS-1:0]   a,
  input  logic [32*NWORDS-1:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [32*NWORDS-1:0]   result,
  output logic                   cout,
  output logic                   ovf,
  output logic                   busy
);

  localparam int KW = $clog2(NWORDS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [NWORDS-1:0][31:0] a_q;
  logic [NWORDS-1:0][31:0] bx_q;
  logic [NWORDS-1:0][31:0] res_q;
  logic [KW-1:0]           k;
  logic                    cy;
  logic                    ovf_q;
  logic [31:0]             sum;
  logic                    co;
  logic                    last;

  assign last = (k == KW'(NWORDS - 1));

  brent_kung_adder u_add (
    .x    (a_q[k]),
    .y    (bx_q[k]),
    .cin  (cy),
    .s    (sum),
    .cout (co)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == IDLE: if (in_valid)  state_d = RUN;
      state_q == RUN:  if (last)      state_d = DONE;
      state_q == DONE: if (out_ready) state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k     <= '0;
      cy    <= 1'b0;
      res_q <= '0;
      ovf_q <= 1'b0;
      a_q   <= '0;
      bx_q  <= '0;
    end else if (state_q == IDLE && in_valid) begin
      a_q  <= a;
      bx_q <= op_sub ? ~b : b;
      cy   <= op_sub;
      k    <= '0;
    end else if (state_q == RUN) begin
      res_q[k] <= sum;
      cy       <= co;
      k        <= last ? '0 : k + KW'(1);
      if (last)
        ovf_q <= (a_q[NWORDS-1][31] == bx_q[NWORDS-1][31]) &&
                 (sum[31] != a_q[NWORDS-1][31]);
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = res_q;
  assign cout      = cy;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bk_mp_add_ctrl.sv
// Bench for bk_mp_add_ctrl: directed table, handshake corner
// sequences and random operands against a 128-bit signed model.

module tb_bk_mp_add_ctrl;

  localparam int N = 4;
  localparam int W = 32 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         op_sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         busy;

  int total = 0;
  int passed = 0;

  always #10 clk = ~clk;

  bk_mp_add_ctrl #(.NWORDS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } vec_t;

  task automatic chk(input string nm, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  function automatic void model(input logic [W-1:0] x, y,
                                input logic s,
                                output logic [W-1:0] r,
                                output logic co, ov);
    logic signed [W:0] sx;
    logic signed [W:0] sy;
    logic signed [W:0] t;
    sx = {x[W-1], x};
    sy = {y[W-1], y};
    t  = s ? sx - sy : sx + sy;
    r  = t[W-1:0];
    ov = t[W] ^ t[W-1];
    if (s) co = (x >= y);
    else   co = ({1'b0, x} + {1'b0, y}) > {1'b0, {W{1'b1}}};
  endfunction

  task automatic run_op(input logic [W-1:0] ta, tb, input logic ts,
                        output logic [W-1:0] r, output logic co, ov,
                        output int lat);
    int n;
    @(negedge clk);
    a = ta; b = tb; op_sub = ts; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    r = result; co = cout; ov = ovf;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  vec_t         vt[5];
  logic [W-1:0] r, er, r1, r2, x1, y1, x2, y2, hold;
  logic         co, ov, eco, eov;
  int           lat, cyc, st;
  logic         seen;

  initial begin
    vt[0] = '{'1, W'(1), 1'b0, '0, 1'b1, 1'b0};
    vt[1] = '{'0, W'(1), 1'b1, '1, 1'b0, 1'b0};
    vt[2] = '{{1'b0, {(W-1){1'b1}}}, W'(1), 1'b0,
              {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1};
    vt[3] = '{{1'b1, {(W-1){1'b0}}}, W'(1), 1'b1,
              {1'b0, {(W-1){1'b1}}}, 1'b1, 1'b1};
    vt[4] = '{W'(5), W'(7), 1'b0, W'(12), 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_result", result, '0);
    chk("rst_cout_ovf", W'({cout, ovf}), W'(0));

    for (int i = 0; i < 5; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].sub, r, co, ov, lat);
      chk($sformatf("vec%0d_res", i), r, vt[i].res);
      chk($sformatf("vec%0d_cout", i), W'(co), W'(vt[i].co));
      chk($sformatf("vec%0d_ovf", i), W'(ov), W'(vt[i].ov));
      chk($sformatf("vec%0d_lat", i), W'(lat), W'(5));
      chk($sformatf("vec%0d_ready", i), W'(in_ready), W'(1));
    end

    // backpressure in DONE with in_valid pulsing
    x1 = {$urandom, $urandom, $urandom, $urandom};
    y1 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    a = x1; b = y1; op_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
    chk("bp_lat", W'(cyc), W'(5));
    hold = result;
    for (int i = 0; i < 3; i++) begin
      a = ~x1; b = ~y1; op_sub = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      chk("bp_stable", result, hold);
      chk("bp_ready_low", W'({in_ready, out_valid}), W'(2'b01));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle", W'({in_ready, busy, out_valid}), W'(3'b100));
    model(x1, y1, 1'b0, er, eco, eov);
    chk("bp_res", hold, er);

    // reset during RUN aborts the request
    @(negedge clk);
    a = '1; b = '1; op_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", W'({in_ready, busy, out_valid}), W'(3'b100));
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_valid", W'(seen), W'(0));
    run_op(W'(5), W'(7), 1'b0, r, co, ov, lat);
    chk("abort_next_res", r, W'(12));

    // back-to-back with in_valid and out_ready held high
    x1 = {$urandom, $urandom, $urandom, $urandom};
    y1 = {$urandom, $urandom, $urandom, $urandom};
    x2 = {$urandom, $urandom, $urandom, $urandom};
    y2 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    a = x1; b = y1; op_sub = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    a = x2; b = y2; op_sub = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
    chk("b2b_lat1", W'(cyc), W'(5));
    r1 = result;
    @(negedge clk);
    chk("b2b_ready", W'(in_ready), W'(1));
    st = 0;
    @(negedge clk);
    in_valid = 1'b0;
    st = 1;
    while (!out_valid && st < 20) begin @(negedge clk); st++; end
    chk("b2b_lat2", W'(st), W'(5));
    r2 = result;
    @(negedge clk);
    out_ready = 1'b0;
    model(x1, y1, 1'b1, er, eco, eov);
    chk("b2b_res1", r1, er);
    model(x2, y2, 1'b0, er, eco, eov);
    chk("b2b_res2", r2, er);

    // random operands against the model
    for (int i = 0; i < 24; i++) begin
      x1 = {$urandom, $urandom, $urandom, $urandom};
      y1 = {$urandom, $urandom, $urandom, $urandom};
      if (i % 6 == 0) y1 = ~x1;
      if (i % 6 == 1) y1 = x1;
      model(x1, y1, i[0], er, eco, eov);
      run_op(x1, y1, i[0], r, co, ov, lat);
      chk($sformatf("rnd%0d_res", i), r, er);
      chk($sformatf("rnd%0d_flags", i), W'({co, ov}), W'({eco, eov}));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
